// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its neighbours: the instruction-memory
// port, the hazard/redirect controls from decode and EX, and the IF/ID outputs.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  // Fetch stage side.
  modport master (
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_fault, fetch_count,
    input  imem_instr, stall, flush, redirect_valid, redirect_target
  );

  // Memory / pipeline-control side.
  modport slave (
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_fault, fetch_count,
    output imem_instr, stall, flush, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, instruction-memory address,
// IF/ID pipeline register, and a sticky trap for misaligned or
// out-of-range fetch addresses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(4 * IMEM_WORDS - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic        pc_legal;

  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

  // Next-state logic: PC selection, IF/ID update and trap handling.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;

    unique case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          // Taken branch/jump wins even over a wrong-path illegal fetch.
          pc_d    = bus.redirect_target;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!pc_legal) begin
          state_d = FAULT;
          fault_d = 1'b1;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else begin
          if (!bus.stall) pc_d = pc_q + 32'd4;
          if (bus.flush) begin
            // Flush beats stall for IF/ID; the PC still honours the stall.
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else if (!bus.stall) begin
            instr_d = bus.imem_instr;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
          end
        end
      end

      FAULT: begin
        // Stall is irrelevant here: nothing is fetched until a redirect.
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_target;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // State register: FSM, PC, IF/ID and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined core: owns the program counter, drives the word address into the instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It handles sequential fetch, branch/jump redirects from EX, decode stalls and pipeline flushes. Fetches outside the populated instruction memory are trapped in a fault state rather than returning stale data.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 32, populated instruction-memory depth in words; legal PCs are 0 .. 4*IMEM_WORDS-4
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  32  byte address to instruction memory; combinationally equal to pc
- imem_instr  in  32  instruction word returned by memory, combinational in same cycle
- stall  in  1  hold PC and IF/ID (load-use hazard from decode)
- flush  in  1  squash IF/ID contents
- redirect_valid  in  1  taken branch / jump / jr resolved in EX
- redirect_target  in  32  new PC when redirect_valid
- pc  out  32  current fetch PC
- if_id_instr  out  32  registered instruction
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_fault  out  1  sticky: PC misaligned or out of range
- fetch_count  out  32  number of instructions captured valid into IF/ID

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Address legal iff pc[1:0]==2'b00 and pc <= 4*IMEM_WORDS-4.
- RUN, pc legal, each edge:
  - PC priority: redirect_valid -> redirect_target; else stall -> hold; else pc+4 (32-bit, wraps mod 2^32).
  - IF/ID priority: flush or redirect_valid -> bubble (valid=0, instr=0, pc4=0); else stall -> hold all three; else capture imem_instr, pc+4, valid=1.
  - fetch_count +1 only on a valid capture; wraps 2^32-1 -> 0.
- RUN, pc illegal: at next edge -> FAULT, fetch_fault=1, IF/ID bubbled, PC held. Unless redirect_valid is high that edge: then redirect takes PC, state stays RUN, no fault (wrong-path fetch).
- FAULT: PC held, IF/ID bubbled every edge, stall ignored. redirect_valid loads redirect_target and returns to RUN; fetch_fault stays 1 until reset.
- Redirect to an illegal target is accepted; fault is evaluated on the following cycle under the RUN rule.
- stall and flush together: flush wins for IF/ID; PC still holds.

## Timing
- Reset (async, on rst_n low, independent of clk): pc=RESET_PC, state RUN, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_fault=0, fetch_count=0.
- imem_addr is pc with zero delay; instruction at PC p appears on if_id_* one edge after p is presented (latency 1).
- First valid IF/ID: first rising edge after rst_n deasserts, holding the word at RESET_PC.
- Redirect: target on pc one edge after redirect_valid; its instruction in IF/ID one edge later; exactly one bubble inserted.
- Reset asserted mid-stall, mid-redirect, or in FAULT: all state cleared immediately; no partial update on the release edge.

## Test plan
- Reset release, memory word n = 32'h1000_0000+n, no stall -> IF/ID shows words 0,1,2 with pc4 4,8,12, valid=1, fetch_count 3 after 3 edges.
- stall high 2 cycles at pc=8 -> pc stays 8, IF/ID holds word 1/pc4 8 for both cycles, fetch_count frozen; resumes with word 2.
- redirect_valid with target 0x40 at pc=0x10 -> next pc=0x40, IF/ID bubble one cycle, then word 16 with pc4 0x44.
- Sequential run to pc=0x7C then 0x80 -> word 31 captured; one edge later state FAULT, fetch_fault=1, pc held 0x80, if_id_valid=0; redirect to 0x0 -> RUN, word 0 fetched, fetch_fault still 1.
- redirect to 0x06 -> fault next edge; stall+flush together at pc=0x8 -> if_id_valid=0, pc holds 0x8.
- rst_n pulsed low between edges during FAULT -> all outputs return to reset values immediately without a clock edge.
